// File: rtl/lamp_sqrt_ctrl.sv
// rtl/lamp_sqrt_ctrl.sv - lampFP sqrt / inverse-sqrt front-end driving the iterative mantissa core
module lamp_sqrt_ctrl #(
    parameter int E_DW    = 8,
    parameter int F_DW    = 7,
    parameter int BIAS    = 127,
    parameter int TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  doSqrt_i,
    input  logic                  doInvSqrt_i,
    input  logic [E_DW+F_DW:0]    op_i,
    output logic [E_DW+F_DW:0]    result_o,
    output logic                  isResultValid_o,
    output logic                  busy_o,
    output logic                  coreDoSqrt_o,
    output logic                  coreDoInvSqrt_o,
    output logic [F_DW+1:0]       coreS_o,
    input  logic [F_DW+1:0]       coreRes_i,
    input  logic                  coreValid_i
);
    localparam int W  = 1 + E_DW + F_DW;
    localparam int SW = F_DW + 2;
    localparam int XW = E_DW + 2;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [W-1:0] QNAN = {1'b0, {E_DW{1'b1}}, 1'b1, {(F_DW-1){1'b0}}};
    localparam logic [W-1:0] PINF = {1'b0, {E_DW{1'b1}}, {F_DW{1'b0}}};
    localparam logic signed [XW-1:0] BIAS_X = XW'(BIAS);
    localparam logic signed [XW-1:0] ONE_X  = XW'(1);

    typedef enum logic [2:0] {IDLE, SPECIAL, ISSUE, WAIT, PACK} state_t;

    state_t                 state;
    logic [W-1:0]           op_r;
    logic                   inv;
    logic                   from_core;
    logic [SW-1:0]          r;
    logic [W-1:0]           pend;
    logic signed [XW-1:0]   e_half;
    logic [CW-1:0]          cnt;

    logic                   in_special;
    logic [SW-1:0]          s_in;
    logic signed [XW-1:0]   e_in;
    logic signed [XW-1:0]   e_half_in;
    logic [W-1:0]           spec_res;
    logic signed [XW-1:0]   adj;
    logic signed [XW-1:0]   exp_n;
    logic [F_DW-1:0]        frac_n;
    logic                   unused_exp_hi;

    // Incoming operand: classification, unbiased exponent and core significand
    always_comb begin
        in_special = (op_i[W-2:F_DW] == '1) || (op_i[W-2:F_DW] == '0) || op_i[W-1];
        e_in       = $signed({2'b00, op_i[W-2:F_DW]}) - BIAS_X;
        e_half_in  = e_in[0] ? ((e_in + ONE_X) >>> 1) : (e_in >>> 1);
        s_in       = e_in[0] ? {1'b0, 1'b1, op_i[F_DW-1:0]} : {1'b1, op_i[F_DW-1:0], 1'b0};
    end

    // Zero/denormal is tested before sign so that -0 keeps its sign
    always_comb begin
        spec_res = QNAN;
        if (op_r[W-2:F_DW] == '1) begin
            if (op_r[F_DW-1:0] == '0 && !op_r[W-1])
                spec_res = inv ? '0 : PINF;
        end else if (op_r[W-2:F_DW] == '0) begin
            spec_res = inv ? {op_r[W-1], {E_DW{1'b1}}, {F_DW{1'b0}}} : {op_r[W-1], {(W-1){1'b0}}};
        end
    end

    always_comb begin
        adj    = r[SW-1] ? '0 : ONE_X;
        exp_n  = inv ? (BIAS_X - e_half - adj) : (e_half + BIAS_X - adj);
        frac_n = r[SW-1] ? r[SW-2:1] : r[SW-3:0];
    end
    assign unused_exp_hi = ^exp_n[XW-1:E_DW];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            op_r            <= '0;
            inv             <= 1'b0;
            from_core       <= 1'b0;
            r               <= '0;
            pend            <= '0;
            e_half          <= '0;
            cnt             <= '0;
            result_o        <= '0;
            isResultValid_o <= 1'b0;
            busy_o          <= 1'b0;
            coreDoSqrt_o    <= 1'b0;
            coreDoInvSqrt_o <= 1'b0;
            coreS_o         <= '0;
        end else begin
            coreDoSqrt_o    <= 1'b0;
            coreDoInvSqrt_o <= 1'b0;
            isResultValid_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (doSqrt_i || doInvSqrt_i) begin
                        op_r      <= op_i;
                        inv       <= !doSqrt_i;
                        from_core <= 1'b0;
                        busy_o    <= 1'b1;
                        if (in_special) begin
                            state <= SPECIAL;
                        end else begin
                            state           <= ISSUE;
                            coreS_o         <= s_in;
                            e_half          <= e_half_in;
                            coreDoSqrt_o    <= doSqrt_i;
                            coreDoInvSqrt_o <= !doSqrt_i;
                        end
                    end
                end
                SPECIAL: begin
                    pend  <= spec_res;
                    state <= PACK;
                end
                ISSUE: begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (coreValid_i) begin
                        r         <= coreRes_i;
                        from_core <= 1'b1;
                        state     <= PACK;
                    end else if (cnt == CW'(TIMEOUT)) begin
                        pend  <= QNAN;
                        state <= PACK;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                PACK: begin
                    result_o        <= from_core ? {1'b0, exp_n[E_DW-1:0], frac_n} : pend;
                    isResultValid_o <= 1'b1;
                    busy_o          <= 1'b0;
                    state           <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lamp_sqrt_ctrl.sv
// tb/tb_lamp_sqrt_ctrl.sv - randomized self-checking bench for lamp_sqrt_ctrl with a behavioural FP model
module tb_lamp_sqrt_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        doSqrt_i = 1'b0;
    logic        doInvSqrt_i = 1'b0;
    logic [15:0] op_i = '0;
    logic [15:0] result_o;
    logic        isResultValid_o;
    logic        busy_o;
    logic        coreDoSqrt_o;
    logic        coreDoInvSqrt_o;
    logic [8:0]  coreS_o;
    logic [8:0]  coreRes_i = '0;
    logic        coreValid_i = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    lamp_sqrt_ctrl dut (
        .clk(clk), .rst(rst),
        .doSqrt_i(doSqrt_i), .doInvSqrt_i(doInvSqrt_i), .op_i(op_i),
        .result_o(result_o), .isResultValid_o(isResultValid_o), .busy_o(busy_o),
        .coreDoSqrt_o(coreDoSqrt_o), .coreDoInvSqrt_o(coreDoInvSqrt_o), .coreS_o(coreS_o),
        .coreRes_i(coreRes_i), .coreValid_i(coreValid_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit is_special(input logic [15:0] op);
        return (op[14:7] == 8'hFF) || (op[14:7] == 8'h00) || op[15];
    endfunction

    // Reference: value-level rules of sqrt / 1/sqrt on lampFP
    function automatic logic [15:0] model(input logic [15:0] op, input bit inv, input int r,
                                          input bit tmo, output int s_exp);
        int e, eh, ex_out, fr_out, adj;
        s_exp = 0;
        if (op[14:7] == 8'hFF) begin
            if (op[6:0] != 0 || op[15]) return 16'h7FC0;
            return inv ? 16'h0000 : 16'h7F80;
        end
        if (op[14:7] == 8'h00) return inv ? {op[15], 15'h7F80} : {op[15], 15'h0};
        if (op[15]) return 16'h7FC0;
        e = int'(op[14:7]) - 127;
        if (e % 2 == 0) begin
            s_exp = 256 + 2 * int'(op[6:0]);
            eh = e / 2;
        end else begin
            s_exp = 128 + int'(op[6:0]);
            eh = (e + 1) / 2;
        end
        if (tmo) return 16'h7FC0;
        adj    = (r >= 256) ? 0 : 1;
        fr_out = (r >= 256) ? (r / 2) % 128 : r % 128;
        ex_out = inv ? (127 - eh - adj) : (eh + 127 - adj);
        return {1'b0, 8'(ex_out), 7'(fr_out)};
    endfunction

    task automatic run_op(input string tag, input bit sq, input bit inv_rq, input logic [15:0] op,
                          input int lat, input int res, input bit respond, input bit poke);
        int cyc, ncmd, cmd_cyc, valid_cyc, countdown, s_exp;
        logic [8:0] s_seen;
        logic [15:0] res_seen, exp_res;
        bit cmd_inv, inv, special, pk, poked_busy;
        inv = !sq;
        special = is_special(op);
        exp_res = model(op, inv, res, !respond, s_exp);
        cyc = 0; ncmd = 0; cmd_cyc = -1; valid_cyc = -1; countdown = -1;
        s_seen = '0; res_seen = '0; cmd_inv = 1'b0; pk = 1'b0; poked_busy = 1'b0;
        @(negedge clk);
        doSqrt_i = sq; doInvSqrt_i = inv_rq; op_i = op;
        while (cyc < 60 && valid_cyc < 0) begin
            @(negedge clk);
            cyc++;
            doSqrt_i = 1'b0; doInvSqrt_i = 1'b0; coreValid_i = 1'b0;
            if (coreDoSqrt_o || coreDoInvSqrt_o) begin
                ncmd += (coreDoSqrt_o && coreDoInvSqrt_o) ? 2 : 1;
                cmd_cyc = cyc; s_seen = coreS_o; cmd_inv = coreDoInvSqrt_o;
                countdown = respond ? lat : -1;
            end else if (countdown > 0) begin
                countdown--;
                if (countdown == 0) begin
                    coreValid_i = 1'b1;
                    coreRes_i = 9'(res);
                end
            end
            if (poke && cmd_cyc > 0 && cyc == cmd_cyc + 2) begin
                doInvSqrt_i = 1'b1; op_i = 16'h3F80; pk = 1'b1;
            end
            if (pk && cyc == cmd_cyc + 3) poked_busy = busy_o;
            if (isResultValid_o) begin
                valid_cyc = cyc; res_seen = result_o;
            end
        end
        coreValid_i = 1'b0;
        check({tag, " valid_seen"}, valid_cyc >= 0, 1);
        check({tag, " result"}, res_seen, exp_res);
        check({tag, " ncmd"}, ncmd, special ? 0 : 1);
        if (special) begin
            check({tag, " latency"}, valid_cyc, 3);
        end else begin
            check({tag, " coreS"}, s_seen, s_exp);
            check({tag, " cmd_inv"}, cmd_inv, inv);
            if (respond) check({tag, " latency"}, valid_cyc, lat + 3);
            else check({tag, " timeout_late"}, (valid_cyc - cmd_cyc) >= 16, 1);
        end
        if (poke) check({tag, " busy_during_drop"}, poked_busy, 1);
        @(negedge clk);
        check({tag, " pulse_once"}, isResultValid_o, 0);
    endtask

    initial begin
        bit seen;
        logic [15:0] op;
        bit sq, iq;
        #12;
        check("rst result", result_o, 0);
        check("rst valid", isResultValid_o, 0);
        check("rst busy", busy_o, 0);
        check("rst cmds", {coreDoSqrt_o, coreDoInvSqrt_o}, 0);
        check("rst coreS", coreS_o, 0);
        @(negedge clk);
        rst = 1'b1;

        run_op("sqrt4", 1, 0, 16'h4080, 3, 'h100, 1, 0);
        run_op("sqrt2", 1, 0, 16'h4000, 2, 'h0B5, 1, 0);
        run_op("isqrt1", 0, 1, 16'h3F80, 1, 'h100, 1, 0);
        run_op("sp_neg", 1, 0, 16'hC000, 0, 0, 1, 0);
        run_op("sp_nzero", 1, 0, 16'h8000, 0, 0, 1, 0);
        run_op("sp_izero", 0, 1, 16'h0000, 0, 0, 1, 0);
        run_op("sp_iinf", 0, 1, 16'h7F80, 0, 0, 1, 0);
        run_op("sp_sinf", 1, 0, 16'h7F80, 0, 0, 1, 0);
        run_op("sp_denorm", 1, 0, 16'h0001, 0, 0, 1, 0);
        run_op("sp_nan", 0, 1, 16'h7FC1, 0, 0, 1, 0);
        run_op("sp_ninf", 1, 0, 16'hFF80, 0, 0, 1, 0);
        run_op("sp_ndenorm", 0, 1, 16'h8005, 0, 0, 1, 0);
        run_op("both", 1, 1, 16'h4080, 4, 'h100, 1, 0);
        run_op("drop", 1, 0, 16'h4080, 6, 'h100, 1, 1);
        run_op("timeout", 0, 1, 16'h4100, 0, 0, 0, 0);

        for (int i = 0; i < 40; i++) begin
            op = 16'($urandom);
            if ($urandom % 4 != 0) op[15] = 1'b0;
            sq = 1'($urandom % 2);
            iq = !sq || ($urandom % 4 == 0);
            run_op($sformatf("rnd%0d", i), sq, iq, op, $urandom_range(1, 8), $urandom_range(0, 511), 1, 0);
        end

        @(negedge clk);
        doSqrt_i = 1'b1; op_i = 16'h4080;
        @(negedge clk);
        doSqrt_i = 1'b0;
        check("rst_mid cmd", coreDoSqrt_o, 1);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("rst_mid busy", busy_o, 0);
        check("rst_mid result", result_o, 0);
        check("rst_mid coreS", coreS_o, 0);
        @(negedge clk);
        rst = 1'b1;
        coreValid_i = 1'b1; coreRes_i = 9'h100;
        @(negedge clk);
        coreValid_i = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            seen |= isResultValid_o;
        end
        check("rst_mid late_valid", seen, 0);
        check("rst_mid idle", busy_o, 0);
        run_op("after_rst", 1, 0, 16'h4080, 2, 'h100, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
